// File: rtl/voice_mixer_pkg.sv
// Shared types, default parameter values and helpers for the voice mixer.
package voice_mixer_pkg;

  localparam int DEF_NUM_CH         = 4;
  localparam int DEF_SAMPLE_W       = 18;
  localparam int DEF_PERIOD_W       = 7;
  localparam int DEF_STACK_DEPTH    = 5;
  localparam int DEF_PERIOD_DEFAULT = 48;
  localparam int DEF_PERIOD_STEP    = 4;
  localparam int DEF_PERIOD_MIN     = 8;
  localparam int DEF_PERIOD_MAX     = 92;

  typedef enum logic [1:0] {
    MIX_IDLE   = 2'd0,
    MIX_ACCUM  = 2'd1,
    MIX_DIVIDE = 2'd2,
    MIX_DONE   = 2'd3
  } mix_state_e;

  // Number of bits needed to encode 'value' distinct codes (ceil(log2)).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/voice_mixer_divider.sv
// Serial restoring divider: one quotient bit per cycle, W cycles per divide.
// The first bit is produced on the start cycle itself, so done pulses W-1
// cycles after start. A zero divisor yields a zero quotient.
module mix_divider
  import voice_mixer_pkg::*;
#(
  parameter int W   = 21,
  parameter int D_W = 3,
  parameter int Q_W = 18
) (
  input  logic           BIT_CLK,
  input  logic           RESET_N,
  input  logic           start,
  input  logic [W-1:0]   dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [Q_W-1:0] quotient
);

  localparam int CNT_W = clog2(W + 1);

  logic [D_W-1:0]   rem_r;
  logic [W-1:0]     quo_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;

  logic             start_ok_s;
  logic [D_W-1:0]   src_rem_s;
  logic [W-1:0]     src_quo_s;
  logic [D_W:0]     shifted_s;
  logic [D_W:0]     diff_s;
  logic [D_W-1:0]   rem_nxt_s;
  logic [W-1:0]     quo_nxt_s;

  // One restoring step on either the fresh operands or the running state.
  always_comb begin
    start_ok_s = start & ~busy_r;
    src_rem_s  = start_ok_s ? {D_W{1'b0}} : rem_r;
    src_quo_s  = start_ok_s ? dividend : quo_r;
    shifted_s  = {src_rem_s, src_quo_s[W-1]};
    diff_s     = shifted_s - {1'b0, divisor};
    if ((divisor != {D_W{1'b0}}) && (shifted_s >= {1'b0, divisor})) begin
      rem_nxt_s = diff_s[D_W-1:0];
      quo_nxt_s = {src_quo_s[W-2:0], 1'b1};
    end else begin
      rem_nxt_s = shifted_s[D_W-1:0];
      quo_nxt_s = {src_quo_s[W-2:0], 1'b0};
    end
  end

  // Iteration counter and remainder/quotient shift register.
  always_ff @(posedge BIT_CLK) begin
    if (!RESET_N) begin
      rem_r  <= {D_W{1'b0}};
      quo_r  <= {W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (start_ok_s) begin
        rem_r  <= rem_nxt_s;
        quo_r  <= quo_nxt_s;
        cnt_r  <= CNT_W'(W - 1);
        busy_r <= 1'b1;
      end else if (busy_r) begin
        rem_r <= rem_nxt_s;
        quo_r <= quo_nxt_s;
        cnt_r <= cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign quotient = quo_r[Q_W-1:0];

endmodule

// File: rtl/voice_mixer.sv
// Voice mixer: switch-driven focus stack selecting the tuned channel, period
// adjustment for the focused channel, and a per-frame averaging mixer.
module voice_mixer
  import voice_mixer_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int SAMPLE_W       = DEF_SAMPLE_W,
  parameter int PERIOD_W       = DEF_PERIOD_W,
  parameter int STACK_DEPTH    = DEF_STACK_DEPTH,
  parameter int PERIOD_DEFAULT = DEF_PERIOD_DEFAULT,
  parameter int PERIOD_STEP    = DEF_PERIOD_STEP,
  parameter int PERIOD_MIN     = DEF_PERIOD_MIN,
  parameter int PERIOD_MAX     = DEF_PERIOD_MAX
) (
  input  logic                         BIT_CLK,
  input  logic                         RESET_N,
  input  logic [NUM_CH-1:0]            SW,
  input  logic                         freq_up,
  input  logic                         freq_down,
  input  logic                         frame_sig,
  input  logic [NUM_CH*SAMPLE_W-1:0]   WAVE_IN,
  input  logic [NUM_CH*PERIOD_W-1:0]   PERIOD_IN,
  output logic [NUM_CH-1:0]            sel,
  output logic [PERIOD_W-1:0]          FRAMES_PER_PERIOD,
  output logic [SAMPLE_W-1:0]          PCM_LR,
  output logic                         pcm_valid,
  output logic                         mix_overrun
);

  localparam int IDX_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam int CNT_W = clog2(NUM_CH + 1);
  localparam int ACC_W = SAMPLE_W + CNT_W;
  localparam logic [PERIOD_W-1:0] P_DEF  = PERIOD_W'(PERIOD_DEFAULT);
  localparam logic [PERIOD_W-1:0] P_STEP = PERIOD_W'(PERIOD_STEP);
  localparam logic [PERIOD_W-1:0] P_UPLIM = PERIOD_W'(PERIOD_MIN + PERIOD_STEP);
  localparam logic [PERIOD_W-1:0] P_DNLIM = PERIOD_W'(PERIOD_MAX - PERIOD_STEP);

  // Focus stack, top of stack at index 0.
  logic [NUM_CH-1:0]      p_sw_r, pend_rise_r, pend_fall_r;
  logic [IDX_W-1:0]       stk_r [STACK_DEPTH];
  logic [STACK_DEPTH-1:0] stk_vld_r;
  logic [NUM_CH-1:0]      sel_r;
  logic                   sel_chg_r;
  logic [PERIOD_W-1:0]    fpp_r;

  logic                   ev_valid_s, ev_rise_s;
  logic [IDX_W-1:0]       ev_ch_s;
  logic [NUM_CH-1:0]      ev_clr_s, pend_rise_nxt_s, pend_fall_nxt_s;
  int                     hit_pos_s;
  logic [IDX_W-1:0]       rem_s [STACK_DEPTH];
  logic [STACK_DEPTH-1:0] rem_vld_s;
  logic [IDX_W-1:0]       stk_nxt_s [STACK_DEPTH];
  logic [STACK_DEPTH-1:0] stk_vld_nxt_s;
  logic [NUM_CH-1:0]      sel_nxt_s;
  logic [PERIOD_W-1:0]    period_sel_s, fpp_nxt_s;

  // Mixer.
  mix_state_e             mix_state_r;
  logic [NUM_CH*SAMPLE_W-1:0] wave_r;
  logic [NUM_CH-1:0]      mask_r;
  logic [CNT_W-1:0]       n_r;
  logic [IDX_W-1:0]       idx_r;
  logic [ACC_W-1:0]       acc_r;
  logic [SAMPLE_W-1:0]    pcm_r;
  logic                   pcm_valid_r, overrun_r;
  logic [SAMPLE_W-1:0]    cur_sample_s;
  logic [ACC_W-1:0]       acc_sum_s;
  logic                   div_start_s, div_busy_s, div_done_s;
  logic [SAMPLE_W-1:0]    div_quo_s;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_CH-1:0] v);
    logic [CNT_W-1:0] c;
    c = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // Pick one pending event: falls first, lowest channel first.
  always_comb begin
    ev_valid_s = 1'b0;
    ev_rise_s  = 1'b0;
    ev_ch_s    = {IDX_W{1'b0}};
    if (|pend_fall_r) begin
      ev_valid_s = 1'b1;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (pend_fall_r[i]) ev_ch_s = IDX_W'(i);
        else                ev_ch_s = ev_ch_s;
      end
    end else if (|pend_rise_r) begin
      ev_valid_s = 1'b1;
      ev_rise_s  = 1'b1;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (pend_rise_r[i]) ev_ch_s = IDX_W'(i);
        else                ev_ch_s = ev_ch_s;
      end
    end else begin
      ev_valid_s = 1'b0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      ev_clr_s[i] = ev_valid_s && (ev_ch_s == IDX_W'(i));
    end
    pend_fall_nxt_s = (pend_fall_r & ~(ev_rise_s ? {NUM_CH{1'b0}} : ev_clr_s)) | (~SW & p_sw_r);
    pend_rise_nxt_s = (pend_rise_r & ~(ev_rise_s ? ev_clr_s : {NUM_CH{1'b0}})) | (SW & ~p_sw_r);
  end

  // Next stack: remove the event channel, then push it on a rise.
  always_comb begin
    hit_pos_s = STACK_DEPTH;
    for (int i = STACK_DEPTH - 1; i >= 0; i--) begin
      if (stk_vld_r[i] && (stk_r[i] == ev_ch_s)) hit_pos_s = i;
      else                                       hit_pos_s = hit_pos_s;
    end
    for (int i = 0; i < STACK_DEPTH - 1; i++) begin
      if (i < hit_pos_s) begin
        rem_s[i] = stk_r[i];     rem_vld_s[i] = stk_vld_r[i];
      end else begin
        rem_s[i] = stk_r[i + 1]; rem_vld_s[i] = stk_vld_r[i + 1];
      end
    end
    if (hit_pos_s == STACK_DEPTH) begin
      rem_s[STACK_DEPTH-1] = stk_r[STACK_DEPTH-1]; rem_vld_s[STACK_DEPTH-1] = stk_vld_r[STACK_DEPTH-1];
    end else begin
      rem_s[STACK_DEPTH-1] = {IDX_W{1'b0}};        rem_vld_s[STACK_DEPTH-1] = 1'b0;
    end
    if (ev_valid_s && ev_rise_s) begin
      stk_nxt_s[0] = ev_ch_s; stk_vld_nxt_s[0] = 1'b1;
      for (int i = 1; i < STACK_DEPTH; i++) begin
        stk_nxt_s[i] = rem_s[i - 1]; stk_vld_nxt_s[i] = rem_vld_s[i - 1];
      end
    end else if (ev_valid_s) begin
      stk_nxt_s = rem_s; stk_vld_nxt_s = rem_vld_s;
    end else begin
      stk_nxt_s = stk_r; stk_vld_nxt_s = stk_vld_r;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      sel_nxt_s[i] = stk_vld_nxt_s[0] && (stk_nxt_s[0] == IDX_W'(i));
    end
  end

  // Period of the focused channel and the next period value.
  always_comb begin
    period_sel_s = P_DEF;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_r[i]) period_sel_s = PERIOD_IN[i*PERIOD_W +: PERIOD_W];
      else          period_sel_s = period_sel_s;
    end
    if (sel_chg_r)                                         fpp_nxt_s = period_sel_s;
    else if (freq_up && !freq_down && (fpp_r >= P_UPLIM))  fpp_nxt_s = fpp_r - P_STEP;
    else if (freq_down && !freq_up && (fpp_r <= P_DNLIM))  fpp_nxt_s = fpp_r + P_STEP;
    else                                                   fpp_nxt_s = fpp_r;
  end

  // Switch edge capture, focus stack, selection and period registers.
  always_ff @(posedge BIT_CLK) begin
    if (!RESET_N) begin
      p_sw_r      <= {NUM_CH{1'b0}};
      pend_rise_r <= {NUM_CH{1'b0}};
      pend_fall_r <= {NUM_CH{1'b0}};
      for (int i = 0; i < STACK_DEPTH; i++) stk_r[i] <= {IDX_W{1'b0}};
      stk_vld_r   <= {STACK_DEPTH{1'b0}};
      sel_r       <= {NUM_CH{1'b0}};
      sel_chg_r   <= 1'b0;
      fpp_r       <= P_DEF;
    end else begin
      p_sw_r      <= SW;
      pend_rise_r <= pend_rise_nxt_s;
      pend_fall_r <= pend_fall_nxt_s;
      stk_r       <= stk_nxt_s;
      stk_vld_r   <= stk_vld_nxt_s;
      sel_r       <= sel_nxt_s;
      sel_chg_r   <= (sel_nxt_s != sel_r);
      fpp_r       <= fpp_nxt_s;
    end
  end

  // Sample added this ACCUM cycle; the last add feeds the divider directly.
  always_comb begin
    cur_sample_s = {SAMPLE_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if ((idx_r == IDX_W'(i)) && mask_r[i]) cur_sample_s = wave_r[i*SAMPLE_W +: SAMPLE_W];
      else                                   cur_sample_s = cur_sample_s;
    end
    acc_sum_s   = acc_r + ACC_W'(cur_sample_s);
    div_start_s = (mix_state_r == MIX_ACCUM) && (idx_r == IDX_W'(NUM_CH - 1)) && !div_busy_s;
  end

  mix_divider #(.W(ACC_W), .D_W(CNT_W), .Q_W(SAMPLE_W)) u_div (
    .BIT_CLK  (BIT_CLK),
    .RESET_N  (RESET_N),
    .start    (div_start_s),
    .dividend (acc_sum_s),
    .divisor  (n_r),
    .busy     (div_busy_s),
    .done     (div_done_s),
    .quotient (div_quo_s)
  );

  // Mix FSM: capture, accumulate, divide, publish.
  always_ff @(posedge BIT_CLK) begin
    if (!RESET_N) begin
      mix_state_r <= MIX_IDLE;
      wave_r      <= {(NUM_CH*SAMPLE_W){1'b0}};
      mask_r      <= {NUM_CH{1'b0}};
      n_r         <= {CNT_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      pcm_r       <= {SAMPLE_W{1'b0}};
      pcm_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      pcm_valid_r <= 1'b0;
      overrun_r   <= frame_sig && (mix_state_r != MIX_IDLE);
      case (mix_state_r)
        MIX_IDLE: begin
          if (frame_sig) begin
            wave_r      <= WAVE_IN;
            mask_r      <= SW;
            n_r         <= popcount(SW);
            idx_r       <= {IDX_W{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            mix_state_r <= MIX_ACCUM;
          end
        end
        MIX_ACCUM: begin
          acc_r <= acc_sum_s;
          if (idx_r == IDX_W'(NUM_CH - 1)) mix_state_r <= MIX_DIVIDE;
          else                             idx_r <= idx_r + IDX_W'(1);
        end
        MIX_DIVIDE: begin
          if (div_done_s) mix_state_r <= MIX_DONE;
        end
        MIX_DONE: begin
          pcm_r       <= div_quo_s;
          pcm_valid_r <= 1'b1;
          mix_state_r <= MIX_IDLE;
        end
        default: mix_state_r <= MIX_IDLE;
      endcase
    end
  end

  assign sel               = sel_r;
  assign FRAMES_PER_PERIOD = fpp_r;
  assign PCM_LR            = pcm_r;
  assign pcm_valid         = pcm_valid_r;
  assign mix_overrun       = overrun_r;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed self-checking bench for voice_mixer with default parameters.
module tb_voice_mixer;

  logic        BIT_CLK;
  logic        RESET_N;
  logic [3:0]  SW;
  logic        freq_up, freq_down, frame_sig;
  logic [71:0] WAVE_IN;
  logic [27:0] PERIOD_IN;
  logic [3:0]  sel;
  logic [6:0]  FRAMES_PER_PERIOD;
  logic [17:0] PCM_LR;
  logic        pcm_valid, mix_overrun;

  int checks = 0;
  int errors = 0;

  voice_mixer dut (
    .BIT_CLK(BIT_CLK), .RESET_N(RESET_N), .SW(SW),
    .freq_up(freq_up), .freq_down(freq_down), .frame_sig(frame_sig),
    .WAVE_IN(WAVE_IN), .PERIOD_IN(PERIOD_IN), .sel(sel),
    .FRAMES_PER_PERIOD(FRAMES_PER_PERIOD), .PCM_LR(PCM_LR),
    .pcm_valid(pcm_valid), .mix_overrun(mix_overrun)
  );

  initial BIT_CLK = 1'b0;
  always #5 BIT_CLK = ~BIT_CLK;

  task automatic tick();
    @(posedge BIT_CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_freq(input logic up, input logic down);
    freq_up = up; freq_down = down;
    tick();
    freq_up = 1'b0; freq_down = 1'b0;
    tick();
  endtask

  // Fire one frame and wait (bounded) for pcm_valid; check latency and value.
  task automatic run_mix(input string tag, input logic [17:0] exp_pcm);
    int  lat;
    bit  found;
    lat = 0; found = 1'b0;
    frame_sig = 1'b1;
    tick();
    frame_sig = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      lat++;
      if (pcm_valid === 1'b1) found = 1'b1;
    end
    check({tag, "_lat"}, lat, 26);
    check(tag, PCM_LR, exp_pcm);
  endtask

  initial begin
    int npulse;
    RESET_N = 1'b0; SW = 4'b0000; freq_up = 1'b0; freq_down = 1'b0; frame_sig = 1'b0;
    WAVE_IN   = {18'd9999, 18'd302, 18'd301, 18'd300};
    PERIOD_IN = {7'd92, 7'd8, 7'd60, 7'd40};
    ticks(3);
    check("rst_sel", sel, 4'b0000);
    check("rst_fpp", FRAMES_PER_PERIOD, 7'd48);
    check("rst_pcm", PCM_LR, 18'd0);
    check("rst_valid", pcm_valid, 1'b0);
    check("rst_ovr", mix_overrun, 1'b0);
    RESET_N = 1'b1;
    tick();

    // Focus follows the most recent switch.
    SW = 4'b0001; ticks(4);
    check("rise0_sel", sel, 4'b0001);
    check("rise0_fpp", FRAMES_PER_PERIOD, 7'd40);
    SW = 4'b0011; ticks(4);
    check("rise1_sel", sel, 4'b0010);
    check("rise1_fpp", FRAMES_PER_PERIOD, 7'd60);
    SW = 4'b0001; ticks(4);
    check("fall1_sel", sel, 4'b0001);
    check("fall1_fpp", FRAMES_PER_PERIOD, 7'd40);
    SW = 4'b0000; ticks(4);
    check("fall0_sel", sel, 4'b0000);
    check("fall0_fpp", FRAMES_PER_PERIOD, 7'd48);

    // Four simultaneous rises are processed on consecutive cycles.
    SW = 4'b1111; tick();
    tick(); check("burst_c1", sel, 4'b0001);
    tick(); check("burst_c2", sel, 4'b0010);
    tick(); check("burst_c3", sel, 4'b0100);
    tick(); check("burst_c4", sel, 4'b1000);
    SW = 4'b0111; ticks(4);
    check("pop3_sel", sel, 4'b0100);
    check("pop3_fpp", FRAMES_PER_PERIOD, 7'd8);
    SW = 4'b0011; ticks(4);
    check("pop2_sel", sel, 4'b0010);
    SW = 4'b0001; ticks(4);
    check("pop1_sel", sel, 4'b0001);
    check("pop1_fpp", FRAMES_PER_PERIOD, 7'd40);

    // Period stepping and limits.
    pulse_freq(1'b0, 1'b1); check("down_40", FRAMES_PER_PERIOD, 7'd44);
    pulse_freq(1'b1, 1'b0); check("up_44", FRAMES_PER_PERIOD, 7'd40);
    SW = 4'b0100; ticks(5);
    check("ch2_sel", sel, 4'b0100);
    check("ch2_fpp", FRAMES_PER_PERIOD, 7'd8);
    pulse_freq(1'b1, 1'b0); check("up_min", FRAMES_PER_PERIOD, 7'd8);
    SW = 4'b1000; ticks(5);
    check("ch3_fpp", FRAMES_PER_PERIOD, 7'd92);
    pulse_freq(1'b0, 1'b1); check("down_max", FRAMES_PER_PERIOD, 7'd92);
    pulse_freq(1'b1, 1'b0); check("up_92", FRAMES_PER_PERIOD, 7'd88);
    SW = 4'b0000; ticks(5);
    check("none_fpp", FRAMES_PER_PERIOD, 7'd48);
    pulse_freq(1'b1, 1'b1); check("both_48", FRAMES_PER_PERIOD, 7'd48);
    pulse_freq(1'b1, 1'b0); check("up_48", FRAMES_PER_PERIOD, 7'd44);

    // Mixing.
    SW = 4'b0111; ticks(5);
    run_mix("mix3", 18'd301);
    tick();
    check("hold_valid", pcm_valid, 1'b0);
    check("hold_pcm", PCM_LR, 18'd301);
    SW = 4'b1111;
    run_mix("mix4", 18'd2725);
    WAVE_IN = {4{18'h3FFFF}};
    run_mix("mixmax", 18'h3FFFF);
    WAVE_IN = {18'd9999, 18'd302, 18'd301, 18'd300};
    SW = 4'b0000;
    run_mix("mix0", 18'd0);

    // A second frame during a mix is flagged and ignored.
    SW = 4'b0111;
    frame_sig = 1'b1; tick(); frame_sig = 1'b0;
    ticks(4);
    frame_sig = 1'b1; tick(); frame_sig = 1'b0;
    check("ovr_pulse", mix_overrun, 1'b1);
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 0) check("ovr_clear", mix_overrun, 1'b0);
      if (pcm_valid === 1'b1) npulse++;
    end
    check("ovr_npulse", npulse, 1);
    check("ovr_pcm", PCM_LR, 18'd301);

    // Reset in the middle of a divide.
    frame_sig = 1'b1; tick(); frame_sig = 1'b0;
    ticks(10);
    RESET_N = 1'b0; tick();
    check("midrst_pcm", PCM_LR, 18'd0);
    check("midrst_sel", sel, 4'b0000);
    RESET_N = 1'b1;
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (pcm_valid === 1'b1) npulse++;
    end
    check("midrst_npulse", npulse, 0);
    check("midrst_pcm2", PCM_LR, 18'd0);
    check("post_rst_sel", sel, 4'b0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
